// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between instruction decode, the ALU
// operation sequencer and register writeback.
// master: the decode/writeback side. slave: the sequencer.
interface alu_op_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Single-issue UM-32 arithmetic sequencer. Add and nand are computed here.
// Mul and div are handed to the shared multi-cycle multiplier_32/divider_32
// units: operands are driven, the unit is held in reset for one LAUNCH cycle,
// released in WAIT, and the result is captured when the unit reports finished.
// A watchdog aborts WAIT after WAIT_LIMIT cycles with rsp_err set.
// Optional macro DIV_ZERO_TRAP_EN: a divide by zero is answered directly
// with rsp_err=1 and never reaches the divider.
module alu_op_sequencer #(
  parameter int unsigned WAIT_LIMIT = 128
) (
  input  logic                clk,
  input  logic                reset,
  alu_op_sequencer_if.slave   bus,
  output logic                busy,
  output logic [31:0]         mul_a,
  output logic [31:0]         mul_b,
  output logic                mul_reset,
  input  logic [31:0]         mul_lo,
  input  logic [31:0]         mul_hi,
  input  logic                mul_finished,
  output logic [31:0]         div_n,
  output logic [31:0]         div_d,
  output logic                div_reset,
  input  logic [31:0]         div_q,
  input  logic [31:0]         div_r,
  input  logic                div_finished
);

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [31:0]        div_n_q, div_n_d, div_d_q, div_d_d;
  logic [31:0]        result_q, result_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sel_finished;

  // The high product word and remainder are not part of any result.
  logic unused_inputs;
  assign unused_inputs = ^{mul_hi, div_r};

  function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  function automatic logic [31:0] f_nand(input logic [31:0] a, input logic [31:0] b);
    return ~(a & b);
  endfunction

  // Handshake and unit-control outputs decoded from the current state.
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.rsp_valid  = (state_q == S_DONE);
    bus.rsp_result = result_q;
    bus.rsp_err    = err_q;
    busy           = (state_q != S_IDLE);
    mul_reset      = !((state_q == S_WAIT) && (op_q == OP_MUL));
    div_reset      = !((state_q == S_WAIT) && (op_q == OP_DIV));
    mul_a          = mul_a_q;
    mul_b          = mul_b_q;
    div_n          = div_n_q;
    div_d          = div_d_q;
    sel_finished   = (op_q == OP_MUL) ? mul_finished : div_finished;
  end

  // Next-state, operand latching, result capture and watchdog.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    div_n_d  = div_n_q;
    div_d_d  = div_d_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d  = bus.req_op;
          err_d = 1'b0;
          unique case (bus.req_op)
            OP_ADD: begin
              result_d = f_add(bus.req_a, bus.req_b);
              state_d  = S_DONE;
            end
            OP_NAND: begin
              result_d = f_nand(bus.req_a, bus.req_b);
              state_d  = S_DONE;
            end
            OP_MUL: begin
              mul_a_d = bus.req_a;
              mul_b_d = bus.req_b;
              state_d = S_LAUNCH;
            end
            default: begin
`ifdef DIV_ZERO_TRAP_EN
              if (bus.req_b == 32'd0) begin
                result_d = 32'd0;
                err_d    = 1'b1;
                state_d  = S_DONE;
              end else begin
                div_n_d = bus.req_a;
                div_d_d = bus.req_b;
                state_d = S_LAUNCH;
              end
`else
              div_n_d = bus.req_a;
              div_d_d = bus.req_b;
              state_d = S_LAUNCH;
`endif
            end
          endcase
        end
      end
      S_LAUNCH: begin
        // Unit still in reset with its operands settled; release next cycle.
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sel_finished) begin
          result_d = (op_q == OP_MUL) ? mul_lo : div_q;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
          result_d = 32'd0;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns everything to a clean idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      div_n_q  <= '0;
      div_d_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      div_n_q  <= div_n_d;
      div_d_q  <= div_d_d;
      result_q <= result_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with behavioural multiplier and
// divider units. Build with or without +define+DIV_ZERO_TRAP_EN.
module tb_alu_op_sequencer;
  localparam int WAIT_LIMIT = 128;
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if bus();
  logic        busy;
  logic [31:0] mul_a, mul_b, div_n, div_d;
  logic        mul_reset, div_reset;
  logic [31:0] mul_lo = '0, mul_hi = '0, div_q = '0, div_r = '0;
  logic        mul_finished = 1'b0, div_finished = 1'b0;

  alu_op_sequencer #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_reset(mul_reset),
    .mul_lo(mul_lo), .mul_hi(mul_hi), .mul_finished(mul_finished),
    .div_n(div_n), .div_d(div_d), .div_reset(div_reset),
    .div_q(div_q), .div_r(div_r), .div_finished(div_finished)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural units: count cycles out of reset, then raise finished.
  int mul_lat = 33;
  int div_lat = 20;
  bit mul_hang = 1'b0;
  int mul_cnt = 0;
  int div_cnt = 0;
  logic [63:0] prod;

  always @(negedge clk) begin
    if (mul_reset) begin
      mul_cnt = 0;
      mul_finished = 1'b0;
    end else begin
      mul_cnt++;
      if (!mul_hang && mul_cnt >= mul_lat) begin
        prod = 64'(mul_a) * 64'(mul_b);
        mul_lo = prod[31:0];
        mul_hi = prod[63:32];
        mul_finished = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (div_reset) begin
      div_cnt = 0;
      div_finished = 1'b0;
    end else begin
      div_cnt++;
      if (div_cnt >= div_lat) begin
        div_q = (div_d == 32'd0) ? 32'hFFFF_FFFF : div_n / div_d;
        div_r = (div_d == 32'd0) ? div_n : div_n % div_d;
        div_finished = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!bus.req_ready && n < 300) begin
      tick();
      n++;
    end
    chk("req_ready_before_send", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic complete();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_after_xfer", 32'(bus.rsp_valid), 32'd0);
    chk("req_ready_after_xfer", 32'(bus.req_ready), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
    int          lat;   // 0: latency not checked
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int   lat, n, wc;
  logic sel_rst, oth_rst, other_ok, stable, saw_low, keep_low;
  logic [31:0] opa, opb;

  initial begin : main
    vecs[0]  = '{OP_ADD,  32'd24,          32'd44,          32'd68,          1'b0, 1};
    vecs[1]  = '{OP_NAND, 32'hF0F0_F0F0,   32'hFF00_FF00,   32'h0FFF_0FFF,   1'b0, 1};
    vecs[2]  = '{OP_ADD,  32'hFFFF_FFFF,   32'd2,           32'd1,           1'b0, 1};
    vecs[3]  = '{OP_ADD,  32'h7FFF_FFFF,   32'd1,           32'h8000_0000,   1'b0, 1};
    vecs[4]  = '{OP_NAND, 32'd0,           32'd0,           32'hFFFF_FFFF,   1'b0, 1};
    vecs[5]  = '{OP_NAND, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'd0,           1'b0, 1};
    vecs[6]  = '{OP_MUL,  32'd56,          32'd44,          32'd2464,        1'b0, 0};
    vecs[7]  = '{OP_MUL,  32'hFFFF_FFFF,   32'd2,           32'hFFFF_FFFE,   1'b0, 0};
    vecs[8]  = '{OP_MUL,  32'h0001_0000,   32'h0001_0000,   32'd0,           1'b0, 0};
    vecs[9]  = '{OP_DIV,  32'd99,          32'd3,           32'd33,          1'b0, 0};
    vecs[10] = '{OP_DIV,  32'd100,         32'd7,           32'd14,          1'b0, 0};
    vecs[11] = '{OP_DIV,  32'h8000_0000,   32'd2,           32'h4000_0000,   1'b0, 0};
    vecs[12] = '{OP_DIV,  32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   1'b0, 0};
    vecs[13] = '{OP_NAND, 32'h1234_5678,   32'hFFFF_0000,   32'hEDCB_FFFF,   1'b0, 1};

    bus.req_valid = 1'b0;
    bus.req_op    = OP_ADD;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    #3 reset = 1'b0;
    #20;
    chk("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    chk("rst_rsp_result", bus.rsp_result,      32'd0);
    chk("rst_rsp_err",    32'(bus.rsp_err),    32'd0);
    chk("rst_mul_reset",  32'(mul_reset),      32'd1);
    chk("rst_div_reset",  32'(div_reset),      32'd1);
    chk("rst_mul_a",      mul_a,               32'd0);
    chk("rst_div_d",      div_d,               32'd0);
    chk("rst_busy",       32'(busy),           32'd0);
    reset = 1'b1;
    tick();
    chk("rst_req_ready",  32'(bus.req_ready),  32'd1);

    // Table-driven functional vectors
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      lat = 1;
      other_ok = 1'b1;
      stable = 1'b1;
      while (!bus.rsp_valid && lat < 400) begin
        if (vecs[i].op == OP_MUL || vecs[i].op == OP_DIV) begin
          sel_rst = (vecs[i].op == OP_MUL) ? mul_reset : div_reset;
          oth_rst = (vecs[i].op == OP_MUL) ? div_reset : mul_reset;
          opa     = (vecs[i].op == OP_MUL) ? mul_a : div_n;
          opb     = (vecs[i].op == OP_MUL) ? mul_b : div_d;
          if (lat == 1) chk("launch_unit_reset_high", 32'(sel_rst), 32'd1);
          if (lat == 2) chk("wait_unit_reset_low", 32'(sel_rst), 32'd0);
          if (!oth_rst) other_ok = 1'b0;
          if (opa !== vecs[i].a || opb !== vecs[i].b) stable = 1'b0;
        end
        tick();
        lat++;
      end
      chk("rsp_valid",  32'(bus.rsp_valid), 32'd1);
      chk("rsp_result", bus.rsp_result,     vecs[i].res);
      chk("rsp_err",    32'(bus.rsp_err),   32'(vecs[i].err));
      if (vecs[i].lat != 0) chk("rsp_latency", 32'(lat), 32'(vecs[i].lat));
      if (vecs[i].op == OP_MUL || vecs[i].op == OP_DIV) begin
        chk("unselected_reset_held", 32'(other_ok), 32'd1);
        chk("operands_stable",       32'(stable),   32'd1);
        chk("done_resets_high",      32'({mul_reset, div_reset}), 32'd3);
      end
      complete();
    end

    // Divide by zero
    send(OP_DIV, 32'd7, 32'd0);
`ifdef DIV_ZERO_TRAP_EN
    chk("dz_rsp_valid_lat1", 32'(bus.rsp_valid), 32'd1);
    chk("dz_rsp_err",        32'(bus.rsp_err),   32'd1);
    chk("dz_rsp_result",     bus.rsp_result,     32'd0);
    chk("dz_div_reset",      32'(div_reset),     32'd1);
    complete();
    chk("dz_div_reset_after", 32'(div_reset), 32'd1);
`else
    saw_low = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 400) begin
      if (!div_reset) saw_low = 1'b1;
      tick();
      n++;
    end
    chk("dz_dispatched",   32'(saw_low),        32'd1);
    chk("dz_rsp_valid",    32'(bus.rsp_valid),  32'd1);
    chk("dz_rsp_result",   bus.rsp_result,      32'hFFFF_FFFF);
    chk("dz_rsp_err",      32'(bus.rsp_err),    32'd0);
    complete();
`endif

    // Backpressure after a mul completes
    send(OP_MUL, 32'd7, 32'd6);
    n = 0;
    while (!bus.rsp_valid && n < 400) begin
      tick();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid",  32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_result", bus.rsp_result,     32'd42);
      chk("bp_req_ready",  32'(bus.req_ready), 32'd0);
      tick();
    end
    complete();
    tick();
    chk("bp_single_transfer", 32'(bus.rsp_valid), 32'd0);

    // Watchdog: multiplier never finishes
    mul_hang = 1'b1;
    send(OP_MUL, 32'd3, 32'd4);
    wc = 0;
    n = 0;
    while (!bus.rsp_valid && n < 400) begin
      if (!mul_reset) wc++;
      tick();
      n++;
    end
    chk("wd_wait_cycles", 32'(wc),            32'(WAIT_LIMIT));
    chk("wd_rsp_valid",   32'(bus.rsp_valid), 32'd1);
    chk("wd_rsp_err",     32'(bus.rsp_err),   32'd1);
    chk("wd_rsp_result",  bus.rsp_result,     32'd0);
    complete();
    mul_hang = 1'b0;

    // Error flag clears on the next accepted request
    send(OP_ADD, 32'd5, 32'd5);
    chk("err_clear_valid",  32'(bus.rsp_valid), 32'd1);
    chk("err_clear_err",    32'(bus.rsp_err),   32'd0);
    chk("err_clear_result", bus.rsp_result,     32'd10);
    complete();

    // Asynchronous reset in the middle of a div WAIT
    send(OP_DIV, 32'd99, 32'd3);
    n = 0;
    while (div_reset && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("mid_wait_div_reset_low", 32'(div_reset), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("ar_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("ar_resets",    32'({mul_reset, div_reset}), 32'd3);
    chk("ar_busy",      32'(busy),          32'd0);
    chk("ar_div_n",     div_n,              32'd0);
    #4 reset = 1'b1;
    tick();
    chk("ar_req_ready", 32'(bus.req_ready), 32'd1);
    keep_low = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (bus.rsp_valid || !div_reset) keep_low = 1'b0;
      tick();
    end
    chk("ar_no_stale_rsp", 32'(keep_low), 32'd1);
    send(OP_ADD, 32'd1, 32'd2);
    chk("ar_after_add", bus.rsp_result, 32'd3);
    complete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
